// File: rtl/viterbi_pkg.sv
// Shared Viterbi helpers: trellis sizing and saturating path-metric arithmetic.
package viterbi_pkg;

   function automatic int unsigned states_n(input int unsigned k);
      return 32'd1 << (k - 32'd1);
   endfunction

   // Adds two unsigned metrics and clamps the result to w bits of all-ones.
   function automatic logic [31:0] pm_sat_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input int unsigned w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage

// File: rtl/pmu_acs_re_pm_min_tree.sv
// Combinational argmin over N packed W-bit values; ties resolve to the lower index.
module pm_min_tree #(
   parameter int unsigned N = 64,
   parameter int unsigned W = 12
) (
   input  logic [N*W-1:0]         vals,
   output logic [W-1:0]           min_val_c,
   output logic [$clog2(N)-1:0]   min_idx_c
);

   localparam int unsigned LVL = $clog2(N);
   localparam int unsigned IW  = LVL;

   logic [W-1:0]  v  [N];
   logic [IW-1:0] ix [N];

   // In-place pairwise reduction; each pass halves the candidates (balanced tree once unrolled).
   always_comb begin : tree_comb
      for (int n = 0; n < N; n++) begin
         v[n]  = vals[n*W +: W];
         ix[n] = IW'(n);
      end
      for (int l = 0; l < LVL; l++) begin
         for (int n = 0; n < int'(N >> (l + 1)); n++) begin
            if (v[2*n+1] < v[2*n]) begin
               v[n]  = v[2*n+1];
               ix[n] = ix[2*n+1];
            end else begin
               v[n]  = v[2*n];
               ix[n] = ix[2*n];
            end
         end
      end
   end

   assign min_val_c = v[0];
   assign min_idx_c = ix[0];

endmodule

// File: rtl/pmu_acs_re.sv
// Add-compare-select path metric unit with register-exchange survivors,
// normalised saturating metrics, minimum search and valid/ready on both sides.
module pmu_acs_re
   import viterbi_pkg::*;
#(
   parameter int unsigned K       = 7,
   parameter int unsigned BM_W    = 4,
   parameter int unsigned PM_W    = 12,
   parameter int unsigned DEPTH   = 60,
   parameter int unsigned PM_INIT = 2**(PM_W-1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [states_n(K)*BM_W-1:0] bm0_i,
   input  logic [states_n(K)*BM_W-1:0] bm1_i,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        data_o,
   output logic [K-2:0]                min_idx_o,
   output logic [PM_W-1:0]             pm_min_o
);

   localparam int unsigned STATES_N = states_n(K);
   localparam int unsigned HALF     = STATES_N / 2;
   localparam int unsigned IDX_W    = K - 1;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

   typedef logic [PM_W-1:0]        pm_t;
   typedef pm_t [STATES_N-1:0]     pm_arr_t;
   typedef logic [DEPTH-1:0]       surv_t;
   typedef surv_t [STATES_N-1:0]   surv_arr_t;
   // The MSB of a stored survivor is never read again, so history keeps DEPTH-1 bits.
   typedef logic [DEPTH-2:0]       hist_t;
   typedef hist_t [STATES_N-1:0]   hist_arr_t;

   function automatic pm_arr_t pm_reset();
      pm_arr_t r;
      for (int i = 0; i < STATES_N; i++) begin
         r[i] = (i == 0) ? '0 : PM_W'(PM_INIT);
      end
      return r;
   endfunction

   localparam pm_arr_t PM_RST = pm_reset();

   function automatic pm_t acs_cand(input pm_t pm, input pm_t min_pm,
                                    input logic [BM_W-1:0] bm);
      return PM_W'(pm_sat_add(32'(pm - min_pm), 32'(bm), PM_W));
   endfunction

   pm_arr_t                 pm_q;
   pm_arr_t                 pm_d;
   hist_arr_t               surv_q;
   hist_arr_t               hist_d;
   surv_arr_t               surv_d;
   pm_t                     c00, c01, c10, c11;
   logic [STATES_N*PM_W-1:0] pm_flat;
   logic [PM_W-1:0]         tree_min;
   logic [IDX_W-1:0]        tree_idx;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic                    accept;
   logic                    load;
   logic                    valid_d;
   logic                    data_d;

   assign ready_o = !flush_i && (!valid_o || ready_i);
   assign accept  = valid_i && ready_o;

   // Butterflies: old states 2s/2s+1 feed new states s (bit 0) and s+HALF (bit 1).
   always_comb begin : acs_comb
      pm_d   = pm_q;
      surv_d = '0;
      hist_d = surv_q;
      c00    = '0;
      c01    = '0;
      c10    = '0;
      c11    = '0;
      for (int unsigned s = 0; s < HALF; s++) begin
         c00 = acs_cand(pm_q[2*s],   pm_min_o, bm0_i[(2*s)*BM_W   +: BM_W]);
         c01 = acs_cand(pm_q[2*s+1], pm_min_o, bm0_i[(2*s+1)*BM_W +: BM_W]);
         c10 = acs_cand(pm_q[2*s],   pm_min_o, bm1_i[(2*s)*BM_W   +: BM_W]);
         c11 = acs_cand(pm_q[2*s+1], pm_min_o, bm1_i[(2*s+1)*BM_W +: BM_W]);
         if (c00 <= c01) begin
            pm_d[s]   = c00;
            surv_d[s] = {surv_q[2*s], 1'b0};
         end else begin
            pm_d[s]   = c01;
            surv_d[s] = {surv_q[2*s+1], 1'b0};
         end
         if (c10 <= c11) begin
            pm_d[s+HALF]   = c10;
            surv_d[s+HALF] = {surv_q[2*s], 1'b1};
         end else begin
            pm_d[s+HALF]   = c11;
            surv_d[s+HALF] = {surv_q[2*s+1], 1'b1};
         end
      end
      for (int i = 0; i < STATES_N; i++) begin
         hist_d[i] = surv_d[i][DEPTH-2:0];
      end
   end

   assign pm_flat = pm_d;

   pm_min_tree #(
      .N (STATES_N),
      .W (PM_W)
   ) u_min_tree (
      .vals      (pm_flat),
      .min_val_c (tree_min),
      .min_idx_c (tree_idx)
   );

   // Fill counter and output register next-state.
   always_comb begin : out_comb
      cnt_d   = cnt_q;
      load    = 1'b0;
      valid_d = valid_o;
      data_d  = data_o;
      if (accept) begin
         if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         load = (cnt_d == CNT_W'(DEPTH));
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = surv_d[tree_idx][DEPTH-1];
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin : state_ff
      if (rst_i) begin
         pm_q      <= PM_RST;
         surv_q    <= '0;
         cnt_q     <= '0;
         pm_min_o  <= '0;
         min_idx_o <= '0;
         valid_o   <= 1'b0;
         data_o    <= 1'b0;
      end else if (flush_i) begin
         pm_q      <= PM_RST;
         surv_q    <= '0;
         cnt_q     <= '0;
         pm_min_o  <= '0;
         min_idx_o <= '0;
         valid_o   <= 1'b0;
         data_o    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_o <= valid_d;
         data_o  <= data_d;
         if (accept) begin
            pm_q      <= pm_d;
            surv_q    <= hist_d;
            pm_min_o  <= tree_min;
            min_idx_o <= tree_idx;
         end
      end
   end

endmodule

// File: tb/tb_pmu_acs_re.sv
// Directed bench for pmu_acs_re at K=3, DEPTH=4, PM_W=6 with hand-derived expectations.
module tb_pmu_acs_re;

   localparam int unsigned K       = 3;
   localparam int unsigned BM_W    = 4;
   localparam int unsigned PM_W    = 6;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PM_INIT = 56;
   localparam int unsigned SN      = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 flush_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [SN*BM_W-1:0]   bm0_i;
   logic [SN*BM_W-1:0]   bm1_i;
   logic                 valid_o;
   logic                 ready_i;
   logic                 data_o;
   logic [K-2:0]         min_idx_o;
   logic [PM_W-1:0]      pm_min_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   pmu_acs_re #(
      .K       (K),
      .BM_W    (BM_W),
      .PM_W    (PM_W),
      .DEPTH   (DEPTH),
      .PM_INIT (PM_INIT)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .bm0_i     (bm0_i),
      .bm1_i     (bm1_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .min_idx_o (min_idx_o),
      .pm_min_o  (pm_min_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Presents one symbol; the unit is expected to be ready, so it is accepted on the next edge.
   task automatic send(input string tag, input logic [15:0] b0, input logic [15:0] b1);
      valid_i = 1'b1;
      bm0_i   = b0;
      bm1_i   = b1;
      #1;
      chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   // Branch metric: 0 on the branch matching the wanted bit, 3 elsewhere, for every state.
   function automatic logic [15:0] bm_of(input bit branch, input bit want);
      return (branch == want) ? 16'h0000 : 16'h3333;
   endfunction

   initial begin
      bit path    [8];
      int exp_idx [8];
      path    = '{1, 0, 1, 1, 0, 0, 0, 0};
      exp_idx = '{2, 1, 2, 3, 1, 0, 0, 0};

      rst_i   = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      bm0_i   = '0;
      bm1_i   = '0;
      #7;
      chk("rst_rdy",   32'(ready_o),   32'd1);
      chk("rst_vld",   32'(valid_o),   32'd0);
      chk("rst_pmmin", 32'(pm_min_o),  32'd0);
      chk("rst_idx",   32'(min_idx_o), 32'd0);
      chk("rst_data",  32'(data_o),    32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();

      // All-zero codeword.
      for (int k = 0; k < 8; k++) begin
         send("zero", 16'h0000, 16'h2222);
         chk("zero_vld",   32'(valid_o),   32'(k >= 3));
         if (k >= 3) chk("zero_data", 32'(data_o), 32'd0);
         chk("zero_pmmin", 32'(pm_min_o),  32'd0);
         chk("zero_idx",   32'(min_idx_o), 32'd0);
      end

      // Flush wins over valid_i; nothing accepted.
      flush_i = 1'b1;
      valid_i = 1'b1;
      bm0_i   = 16'h3333;
      bm1_i   = 16'h0000;
      #1;
      chk("flush_rdy", 32'(ready_o), 32'd0);
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_vld", 32'(valid_o),   32'd0);
      chk("flush_idx", 32'(min_idx_o), 32'd0);

      // Known path 1,0,1,1,0,0,0,0.
      for (int k = 0; k < 8; k++) begin
         send("path", bm_of(1'b0, path[k]), bm_of(1'b1, path[k]));
         chk("path_idx",   32'(min_idx_o), 32'(exp_idx[k]));
         chk("path_vld",   32'(valid_o),   32'(k >= 3));
         if (k >= 3) chk("path_data", 32'(data_o), 32'(path[k-3]));
         chk("path_pmmin", 32'(pm_min_o),  32'd0);
      end

      // Back-pressure after the first output.
      do_flush();
      for (int k = 0; k < 4; k++) begin
         send("bp", bm_of(1'b0, path[k]), bm_of(1'b1, path[k]));
      end
      chk("bp_first_vld",  32'(valid_o), 32'd1);
      chk("bp_first_data", 32'(data_o),  32'd1);
      ready_i = 1'b0;
      valid_i = 1'b1;
      bm0_i   = bm_of(1'b0, path[4]);
      bm1_i   = bm_of(1'b1, path[4]);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_stall_rdy", 32'(ready_o), 32'd0);
         tick();
         chk("bp_stall_vld",  32'(valid_o),   32'd1);
         chk("bp_stall_data", 32'(data_o),    32'd1);
         chk("bp_stall_idx",  32'(min_idx_o), 32'd3);
      end
      ready_i = 1'b1;
      valid_i = 1'b0;
      for (int k = 4; k < 8; k++) begin
         send("bp_run", bm_of(1'b0, path[k]), bm_of(1'b1, path[k]));
         chk("bp_run_vld",  32'(valid_o),   32'd1);
         chk("bp_run_data", 32'(data_o),    32'(path[k-3]));
         chk("bp_run_idx",  32'(min_idx_o), 32'(exp_idx[k]));
      end

      // Flush while an output is stalled: dropped, then refill needs DEPTH accepts.
      ready_i = 1'b0;
      flush_i = 1'b1;
      valid_i = 1'b1;
      tick();
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      chk("fl_stall_vld", 32'(valid_o),   32'd0);
      chk("fl_stall_idx", 32'(min_idx_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         send("fl_refill", bm_of(1'b0, path[k]), bm_of(1'b1, path[k]));
         chk("fl_refill_vld", 32'(valid_o), 32'(k == 3));
         chk("fl_refill_idx", 32'(min_idx_o), 32'(exp_idx[k]));
      end
      chk("fl_refill_data", 32'(data_o), 32'(path[0]));

      // Saturation and ties: equal metrics of 15 everywhere.
      do_flush();
      for (int k = 0; k < 10; k++) begin
         send("sat", 16'hFFFF, 16'hFFFF);
         chk("sat_pmmin", 32'(pm_min_o),  32'd15);
         chk("sat_idx",   32'(min_idx_o), 32'd0);
         chk("sat_vld",   32'(valid_o),   32'(k >= 3));
         if (k >= 3) chk("sat_data", 32'(data_o), 32'd0);
      end

      // Asynchronous reset mid-stream, between clock edges.
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_vld",   32'(valid_o),   32'd0);
      chk("arst_pmmin", 32'(pm_min_o),  32'd0);
      chk("arst_idx",   32'(min_idx_o), 32'd0);
      chk("arst_rdy",   32'(ready_o),   32'd1);
      chk("arst_data",  32'(data_o),    32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         send("arst_run", 16'h0000, 16'h2222);
         chk("arst_run_vld", 32'(valid_o), 32'(k == 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
